mul_arbiter: RTL and testbench

//  Round-robin scheduler sharing one shift-add multiplier (req/ack pulse handshake, N-bit operands, 2N-bit product) among NREQ clients.

---
 rtl/mul_arbiter.sv | 103 ++++++++++
 tb/tb_mul_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin scheduler sharing one req/ack shift-add multiplier among NREQ clients
// Ports: clk, rst (sync, active-high); req/a_bus/b_bus client requests and operands;
// gnt/done one-hot client pulses, err timeout flag, result 2N-bit product, busy;
// mul_req/mul_sn/mul_sbn/mul_rst_n drive the multiplier, mul_tich/mul_ack come back from it.
module mul_arbiter #(
  parameter int N = 8,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_bus,
  input  logic [NREQ*N-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [2*N-1:0]    result,
  output logic              busy,
  output logic              mul_req,
  output logic [N-1:0]      mul_sn,
  output logic [N-1:0]      mul_sbn,
  output logic              mul_rst_n,
  input  logic [2*N-1:0]    mul_tich,
  input  logic              mul_ack
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, owner, pick, idx;
  logic [CW-1:0] cnt;
  logic abort;
  logic [N-1:0] a_arr [NREQ];
  logic [N-1:0] b_arr [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign a_arr[k] = a_bus[k*N +: N];
    assign b_arr[k] = b_bus[k*N +: N];
  end
  // Scan offsets from farthest to nearest so the first set bit at/after ptr wins.
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  // An ack arriving in the last allowed cycle takes precedence over the timeout.
  assign abort = state == WAIT && !mul_ack && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = |req ? ISSUE : IDLE;
      ISSUE: state_n = WAIT;
      WAIT:  state_n = (mul_ack || abort) ? DONE : WAIT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      result <= '0;
      busy <= 1'b0;
      mul_req <= 1'b0;
      mul_sn <= '0;
      mul_sbn <= '0;
      mul_rst_n <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      gnt <= '0;
      done <= '0;
      err <= 1'b0;
      mul_req <= 1'b0;
      mul_rst_n <= ~abort;
      if (state == IDLE && |req) begin
        owner <= pick;
        ptr <= PW'((int'(pick) + 1) % NREQ);
        mul_sn <= a_arr[pick];
        mul_sbn <= b_arr[pick];
        gnt <= NREQ'(1) << pick;
        mul_req <= 1'b1;
      end
      // Counter saturates at TIMEOUT so it can never wrap back into range.
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
      if (state == WAIT && (mul_ack || abort)) begin
        result <= mul_ack ? mul_tich : '0;
        done <= NREQ'(1) << owner;
        err <= abort;
      end
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized self-checking bench for mul_arbiter against a transaction-level model
module tb_mul_arbiter;
  localparam int N = 8;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*N-1:0] a_bus = '0, b_bus = '0;
  logic [NREQ-1:0] gnt, done;
  logic err, busy, mul_req, mul_rst_n;
  logic [2*N-1:0] result;
  logic [N-1:0] mul_sn, mul_sbn;
  logic [2*N-1:0] mul_tich = '0;
  logic mul_ack = 1'b0;
  int pass = 0, total = 0;
  int mptr = 0;
  logic [2*N-1:0] exp_res = '0;
  mul_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .mul_req(mul_req), .mul_sn(mul_sn), .mul_sbn(mul_sbn), .mul_rst_n(mul_rst_n),
    .mul_tich(mul_tich), .mul_ack(mul_ack)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction
  function automatic logic [NREQ-1:0] onehot(int k);
    logic [NREQ-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction
  // One full transaction from an IDLE cycle; d<0 means the multiplier never acks.
  task automatic txn(input int d, input bit drop, input bit rnd, input string tag);
    int k;
    logic [2*N-1:0] aw, bw, exp;
    logic [NREQ-1:0] oh;
    if (rnd) for (int i = 0; i < NREQ; i++) begin
      a_bus[i*N +: N] = N'($urandom);
      b_bus[i*N +: N] = N'($urandom);
    end
    k = rr_pick(req, mptr);
    oh = onehot(k);
    aw = {{N{1'b0}}, a_bus[k*N +: N]};
    bw = {{N{1'b0}}, b_bus[k*N +: N]};
    exp = (d < 0) ? '0 : aw * bw;
    tick();
    total++; if (gnt !== oh) $display("FAIL %s gnt: got %b expected %b", tag, gnt, oh); else pass++;
    total++; if (mul_req !== 1'b1 || busy !== 1'b1) $display("FAIL %s issue: mul_req=%b busy=%b expected 1 1", tag, mul_req, busy); else pass++;
    total++; if ({mul_sn, mul_sbn} !== {aw[N-1:0], bw[N-1:0]}) $display("FAIL %s operands: got %0d,%0d expected %0d,%0d", tag, mul_sn, mul_sbn, aw, bw); else pass++;
    mptr = (k + 1) % NREQ;
    if (drop) req[k] = 1'b0;
    tick();
    total++; if (gnt !== '0 || mul_req !== 1'b0) $display("FAIL %s wait_entry: gnt=%b mul_req=%b expected 0 0", tag, gnt, mul_req); else pass++;
    if (d < 0) begin
      mul_tich = 2*N'($urandom);
      repeat (TIMEOUT - 1) tick();
    end else begin
      repeat (d) tick();
      mul_ack = 1'b1;
      mul_tich = exp;
    end
    total++; if (done !== '0 || busy !== 1'b1) $display("FAIL %s early_done: done=%b busy=%b expected 0 1", tag, done, busy); else pass++;
    tick();
    mul_ack = 1'b0;
    total++; if (done !== oh) $display("FAIL %s done: got %b expected %b", tag, done, oh); else pass++;
    total++; if (result !== exp) $display("FAIL %s result: got %0d expected %0d", tag, result, exp); else pass++;
    total++; if (err !== (d < 0) || mul_rst_n !== (d >= 0)) $display("FAIL %s err: err=%b mul_rst_n=%b expected %b %b", tag, err, mul_rst_n, d < 0, d >= 0); else pass++;
    exp_res = exp;
    tick();
    total++; if (done !== '0 || err !== 1'b0 || busy !== 1'b0 || mul_rst_n !== 1'b1) $display("FAIL %s idle: done=%b err=%b busy=%b mul_rst_n=%b expected 0 0 0 1", tag, done, err, busy, mul_rst_n); else pass++;
    total++; if (result !== exp) $display("FAIL %s result_hold: got %0d expected %0d", tag, result, exp); else pass++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if ({busy, gnt, done, err, mul_req} !== '0) $display("FAIL reset_ctrl: got %b expected 0", {busy, gnt, done, err, mul_req}); else pass++;
    total++; if ({result, mul_sn, mul_sbn} !== '0) $display("FAIL reset_data: got %h expected 0", {result, mul_sn, mul_sbn}); else pass++;
    total++; if (mul_rst_n !== 1'b0) $display("FAIL reset_mul_rst_n: got %b expected 0", mul_rst_n); else pass++;
    rst = 1'b0;
    mptr = 0;
    exp_res = '0;
    tick();
    total++; if (mul_rst_n !== 1'b1) $display("FAIL reset_release: mul_rst_n got %b expected 1", mul_rst_n); else pass++;
  endtask
  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    req = '1;
    for (int i = 0; i < 5; i++) begin
      total++; if (rr_pick(req, mptr) !== order[i]) $display("FAIL rr_order: got %0d expected %0d", rr_pick(req, mptr), order[i]); else pass++;
      txn($urandom_range(0, 8), 1'b0, 1'b1, "rr_all");
    end
    req = 4'b1001;
    txn(2, 1'b1, 1'b1, "rr_3_before_0");
    txn(3, 1'b1, 1'b1, "rr_then_0");
  endtask
  task automatic test_basic();
    req = 4'b0100;
    a_bus[2*N +: N] = 8'd13;
    b_bus[2*N +: N] = 8'd11;
    txn(10, 1'b1, 1'b0, "basic_143");
    total++; if (exp_res !== 16'd143) $display("FAIL basic_model: got %0d expected 143", exp_res); else pass++;
  endtask
  task automatic test_full_width();
    req = 4'b0010;
    a_bus = '1;
    b_bus = '1;
    txn(5, 1'b1, 1'b0, "full_width");
    total++; if (result !== 16'hFE01) $display("FAIL full_width_const: got %h expected fe01", result); else pass++;
  endtask
  task automatic test_timeout();
    req = 4'b1000;
    txn(-1, 1'b1, 1'b1, "timeout");
    req = 4'b0001;
    txn(4, 1'b1, 1'b1, "after_timeout");
  endtask
  task automatic test_stray_ack();
    int k;
    logic [2*N-1:0] exp;
    mul_ack = 1'b1;
    mul_tich = 2*N'($urandom);
    tick();
    mul_ack = 1'b0;
    total++; if (done !== '0 || result !== exp_res || busy !== 1'b0) $display("FAIL stray_idle: done=%b result=%0d busy=%b expected 0 %0d 0", done, result, busy, exp_res); else pass++;
    req = 4'b0010;
    a_bus[N +: N] = N'($urandom);
    b_bus[N +: N] = N'($urandom);
    k = rr_pick(req, mptr);
    tick();
    total++; if (gnt !== onehot(k)) $display("FAIL stray_gnt: got %b expected %b", gnt, onehot(k)); else pass++;
    mptr = (k + 1) % NREQ;
    req = '0;
    mul_ack = 1'b1;
    mul_tich = 2*N'($urandom);
    tick();
    mul_ack = 1'b0;
    total++; if (done !== '0 || result !== exp_res || busy !== 1'b1) $display("FAIL stray_issue: done=%b result=%0d busy=%b expected 0 %0d 1", done, result, busy, exp_res); else pass++;
    exp = {{N{1'b0}}, a_bus[N +: N]} * {{N{1'b0}}, b_bus[N +: N]};
    tick();
    tick();
    mul_ack = 1'b1;
    mul_tich = exp;
    tick();
    mul_ack = 1'b0;
    total++; if (done !== onehot(k) || result !== exp) $display("FAIL stray_recover: done=%b result=%0d expected %b %0d", done, result, onehot(k), exp); else pass++;
    exp_res = exp;
    tick();
    req = onehot($urandom_range(0, NREQ - 1));
    txn(TIMEOUT - 1, 1'b1, 1'b1, "ack_at_timeout");
  endtask
  task automatic test_reset_mid();
    req = 4'b0001;
    txn(1, 1'b1, 1'b1, "pre_reset");
    req = '1;
    tick();
    req = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || done !== '0 || mul_rst_n !== 1'b0 || result !== '0) $display("FAIL mid_reset: busy=%b done=%b mul_rst_n=%b result=%0d expected 0 0 0 0", busy, done, mul_rst_n, result); else pass++;
    rst = 1'b0;
    mptr = 0;
    exp_res = '0;
    mul_ack = 1'b1;
    tick();
    mul_ack = 1'b0;
    total++; if (done !== '0 || mul_rst_n !== 1'b1) $display("FAIL mid_reset_release: done=%b mul_rst_n=%b expected 0 1", done, mul_rst_n); else pass++;
    tick();
    total++; if (done !== '0 || busy !== 1'b0) $display("FAIL mid_reset_nodone: done=%b busy=%b expected 0 0", done, busy); else pass++;
    req = '1;
    txn(3, 1'b1, 1'b1, "post_reset_client0");
    req = '0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      txn(($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1)), 1'b1, 1'b1, "random");
      req = '0;
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_full_width();
    test_timeout();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
